// File: rtl/spi_reg_controller_if.sv
// Byte-level link between the SPI slave shifter and the register controller.
// The shifter side drives frame/byte events; the controller side answers with bytes to transmit.
interface spi_reg_controller_if;
  logic       frame_start;
  logic       frame_end;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_load;

  modport master (
    output frame_start, frame_end, rx_valid, rx_byte,
    input  tx_byte, tx_load
  );

  modport slave (
    input  frame_start, frame_end, rx_valid, rx_byte,
    output tx_byte, tx_load
  );
endinterface

// File: rtl/spi_reg_controller.sv
// Command decoder and burst register file behind an SPI slave byte interface.
// Every response byte is loaded exactly one cycle after its frame_start or rx_valid.
module spi_reg_controller #(
  parameter int          ADDR_W  = 3,
  parameter logic [7:0]  ID_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_reg_controller_if.slave          bus,
  input  logic [7:0]                   status_in,
  output logic [8*(2**ADDR_W)-1:0]     regs_q,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         busy,
  output logic [7:0]                   frame_cnt,
  output logic [7:0]                   err_cnt
);

  localparam int                DEPTH       = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        ERR_BYTE    = 8'hEE;

  typedef enum logic [2:0] {IDLE, CMD, WR, RD, DRAIN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        tx_byte_q;
  logic              tx_load_q;
  logic              wr_pulse_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        frame_cnt_q;
  logic [7:0]        err_cnt_q;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_bad;
  logic [ADDR_W-1:0] ptr_d;
  logic [7:0]        rd_cmd_val;
  logic [7:0]        rd_next_val;
  logic [7:0]        frame_cnt_d;
  logic [7:0]        err_cnt_d;

  always_comb begin
    cmd_addr    = bus.rx_byte[ADDR_W-1:0];
    // Any set bit between the R/W flag and the address field marks an unknown command.
    cmd_bad     = ((bus.rx_byte[6:0] >> ADDR_W) != 7'd0);
    ptr_d       = ptr_q + 1'b1;
    rd_cmd_val  = (cmd_addr == STATUS_ADDR) ? status_in : mem_q[cmd_addr];
    rd_next_val = (ptr_d == STATUS_ADDR) ? status_in : mem_q[ptr_d];
    frame_cnt_d = frame_cnt_q + 8'd1;
    err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tx_byte_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_cnt_q <= 8'h00;
      err_cnt_q   <= 8'h00;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= 8'h00;
    end else begin
      tx_load_q  <= 1'b0;
      wr_pulse_q <= 1'b0;
      if (bus.frame_start) begin
        // A new frame always restarts at the command slot, even mid-transaction.
        state_q     <= CMD;
        frame_cnt_q <= frame_cnt_d;
        tx_byte_q   <= ID_BYTE;
        tx_load_q   <= 1'b1;
      end else begin
        if (bus.rx_valid && state_q != IDLE) begin
          tx_load_q <= 1'b1;
          case (state_q)
            CMD: begin
              if (cmd_bad) begin
                state_q   <= DRAIN;
                err_cnt_q <= err_cnt_d;
                tx_byte_q <= ERR_BYTE;
              end else begin
                ptr_q <= cmd_addr;
                if (bus.rx_byte[7]) begin
                  state_q   <= RD;
                  tx_byte_q <= rd_cmd_val;
                end else begin
                  state_q   <= WR;
                  tx_byte_q <= 8'h00;
                end
              end
            end
            WR: begin
              if (ptr_q != STATUS_ADDR) begin
                mem_q[ptr_q] <= bus.rx_byte;
                wr_pulse_q   <= 1'b1;
                wr_addr_q    <= ptr_q;
              end
              ptr_q     <= ptr_d;
              tx_byte_q <= 8'h00;
            end
            RD: begin
              ptr_q     <= ptr_d;
              tx_byte_q <= rd_next_val;
            end
            DRAIN: tx_byte_q <= ERR_BYTE;
            default: tx_byte_q <= tx_byte_q;
          endcase
        end
        // Overrides the per-state next state so a final byte still completes first.
        if (bus.frame_end && state_q != IDLE) state_q <= IDLE;
      end
    end
  end

  always_comb begin
    regs_q = '0;
    for (int k = 0; k < DEPTH; k++) regs_q[8*k +: 8] = mem_q[k];
  end

  assign bus.tx_byte = tx_byte_q;
  assign bus.tx_load = tx_load_q;
  assign wr_pulse    = wr_pulse_q;
  assign wr_addr     = wr_addr_q;
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller: tx bytes and writes go through scoreboard queues
// that are checked, with their expected cycle, whenever the DUT pulses tx_load or wr_pulse.
module tb_spi_reg_controller;
  localparam int AW = 3;
  localparam int N  = 8;

  typedef struct packed { logic [7:0] b; logic [31:0] cyc; } tx_exp_t;
  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; logic [31:0] cyc; } wr_exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      status_in = 8'h00;
  logic [8*N-1:0]  regs_q;
  logic            wr_pulse;
  logic [AW-1:0]   wr_addr;
  logic            busy;
  logic [7:0]      frame_cnt;
  logic [7:0]      err_cnt;

  spi_reg_controller_if bus ();

  spi_reg_controller #(.ADDR_W(AW), .ID_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .status_in (status_in),
    .regs_q    (regs_q),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc = 0;
  int          n_frames = 0;
  logic [7:0]  exp_regs [N];
  tx_exp_t     txq [$];
  wr_exp_t     wrq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] packed_regs();
    logic [63:0] v;
    for (int k = 0; k < N; k++) v[8*k +: 8] = exp_regs[k];
    return v;
  endfunction

  // Scoreboard consumers: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.tx_load === 1'b1) begin
      if (txq.size() == 0) chk("tx_unexpected", 64'(txq.size()), 64'd1);
      else begin
        tx_exp_t e;
        e = txq.pop_front();
        chk("tx_byte_cycle", {24'd0, bus.tx_byte, cyc}, {24'd0, e.b, e.cyc});
      end
    end
    if (wr_pulse === 1'b1) begin
      if (wrq.size() == 0) chk("wr_unexpected", 64'(wrq.size()), 64'd1);
      else begin
        wr_exp_t w;
        w = wrq.pop_front();
        chk("wr_commit", {21'd0, wr_addr, regs_q[8*wr_addr +: 8], cyc}, {21'd0, w.a, w.d, w.cyc});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fstart();
    bus.frame_start = 1'b1;
    txq.push_back('{b: 8'hA5, cyc: cyc + 1});
    n_frames++;
    tick(1);
    bus.frame_start = 1'b0;
    tick(1);
  endtask

  task automatic rx(input logic [7:0] b, input logic [7:0] exp_tx, input logic fe);
    bus.rx_valid  = 1'b1;
    bus.rx_byte   = b;
    bus.frame_end = fe;
    txq.push_back('{b: exp_tx, cyc: cyc + 1});
    tick(1);
    bus.rx_valid  = 1'b0;
    bus.frame_end = 1'b0;
    tick(1);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wrq.push_back('{a: a, d: d, cyc: cyc + 1});
    exp_regs[a] = d;
  endtask

  task automatic fend();
    bus.frame_end = 1'b1;
    tick(1);
    bus.frame_end = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = 8'h00;
    for (int k = 0; k < N; k++) exp_regs[k] = 8'h00;

    tick(2);
    chk("rst_regs", regs_q, 64'd0);
    chk("rst_tx", {bus.tx_load, bus.tx_byte, wr_pulse, 5'(wr_addr)}, 15'd0);
    chk("rst_cnt", {busy, frame_cnt, err_cnt}, 17'd0);
    rst_n = 1'b1;
    tick(2);

    // First frame: burst write at 2.
    fstart();
    chk("fs_frame_cnt", frame_cnt, 8'd1);
    chk("fs_busy", busy, 1'b1);
    rx(8'h02, 8'h00, 1'b0);
    expect_wr(2, 8'h11); rx(8'h11, 8'h00, 1'b0);
    expect_wr(3, 8'h22); rx(8'h22, 8'h00, 1'b0);
    fend();
    chk("wr_busy_after_end", busy, 1'b0);
    chk("wr_regs_2_3", regs_q, packed_regs());

    fstart();
    rx(8'h06, 8'h00, 1'b0);
    expect_wr(6, 8'h66); rx(8'h66, 8'h00, 1'b0);
    fend();

    // Burst starting on the read-only location: first byte dropped, then wraps to 0.
    fstart();
    rx(8'h07, 8'h00, 1'b0);
    rx(8'hFF, 8'h00, 1'b0);
    expect_wr(0, 8'h33); rx(8'h33, 8'h00, 1'b0);
    fend();
    chk("wr7_regs", regs_q, packed_regs());

    // Burst read through the status location and the wrap.
    status_in = 8'h5A;
    fstart();
    rx(8'h86, 8'h66, 1'b0);
    rx(8'h00, 8'h5A, 1'b0);
    rx(8'h00, 8'h33, 1'b0);
    rx(8'h00, 8'h00, 1'b0);
    fend();
    chk("rd_regs_unchanged", regs_q, packed_regs());

    // Invalid command drains the frame.
    fstart();
    rx(8'h48, 8'hEE, 1'b0);
    rx(8'hAB, 8'hEE, 1'b0);
    rx(8'hCD, 8'hEE, 1'b0);
    fend();
    chk("inv_err_cnt", err_cnt, 8'd1);
    chk("inv_regs", regs_q, packed_regs());

    for (int i = 0; i < 253; i++) begin
      fstart();
      rx(8'h48, 8'hEE, 1'b0);
      fend();
    end
    chk("err_cnt_254", err_cnt, 8'hFE);
    for (int i = 0; i < 3; i++) begin
      fstart();
      rx(8'h48, 8'hEE, 1'b0);
      fend();
    end
    chk("err_cnt_sat", err_cnt, 8'hFF);
    chk("frame_cnt_wrap", frame_cnt, 8'(n_frames));

    // Last data byte arrives together with frame_end.
    fstart();
    rx(8'h04, 8'h00, 1'b0);
    expect_wr(4, 8'h44); rx(8'h44, 8'h00, 1'b1);
    chk("coinc_busy", busy, 1'b0);
    chk("coinc_regs", regs_q, packed_regs());

    // Restart during a read: the coincident byte is ignored.
    fstart();
    rx(8'h81, 8'h00, 1'b0);
    bus.frame_start = 1'b1;
    bus.rx_valid    = 1'b1;
    bus.rx_byte     = 8'h55;
    txq.push_back('{b: 8'hA5, cyc: cyc + 1});
    n_frames++;
    tick(1);
    bus.frame_start = 1'b0;
    bus.rx_valid    = 1'b0;
    tick(1);
    chk("restart_frame_cnt", frame_cnt, 8'(n_frames));
    chk("restart_busy", busy, 1'b1);
    rx(8'h02, 8'h00, 1'b0);
    expect_wr(2, 8'h77); rx(8'h77, 8'h00, 1'b0);
    fend();
    chk("restart_regs", regs_q, packed_regs());

    // Bytes outside a frame are ignored.
    rx(8'h12, 8'h00, 1'b0);
    void'(txq.pop_back());
    tick(2);
    chk("idle_rx_busy", busy, 1'b0);

    // Reset while a write burst is open.
    fstart();
    rx(8'h00, 8'h00, 1'b0);
    expect_wr(0, 8'h99); rx(8'h99, 8'h00, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick(1);
    for (int k = 0; k < N; k++) exp_regs[k] = 8'h00;
    n_frames = 0;
    chk("midrst_regs", regs_q, 64'd0);
    chk("midrst_state", {busy, frame_cnt, err_cnt, bus.tx_byte}, 25'd0);
    rst_n = 1'b1;
    tick(2);
    rx(8'h01, 8'h00, 1'b0);
    void'(txq.pop_back());
    chk("postrst_idle", busy, 1'b0);
    fstart();
    chk("postrst_frame_cnt", frame_cnt, 8'd1);
    fend();

    tick(3);
    chk("txq_drained", 64'(txq.size()), 64'd0);
    chk("wrq_drained", 64'(wrq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
